uart_tx: RTL

Serial transmitter that produces the same framing `uart_rx` consumes: line idles low, one high start bit, eight data bits LSB first, one low stop bit, each bit held for `DIV` clock cycles. It sits directly upstream of `uart_rx`: a byte source hands it parallel bytes over a valid/ready handshake, and its `out` drives the serial line or a receiver's `in`. An optional one-byte holding register allows gap-free back-to-back frames.

---
 rtl/uart_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// UartTx -- serial byte transmitter (module name uart_tx)
//
// Sends one byte per frame on a line that idles low: a high start bit, eight
// data bits LSB first, then a low stop bit. Every bit lasts DIV clock cycles,
// so a frame is exactly 10*DIV cycles. Bytes arrive over a valid/ready
// handshake and are taken on any rising edge where valid && ready.
//
// Optional feature macro: UART_TX_HOLD_EN
//   defined   -> a one-byte holding slot lets a byte be accepted while a frame
//                is on the line, and the next start bit follows the stop bit
//                with no idle cycle in between. ready = slot empty.
//   undefined -> no slot; ready is high only while idle, so back-to-back
//                frames are separated by exactly one idle cycle.
//
// Parameters:
//   DIV    clock cycles per bit, 2..256 (default 8)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   in     in   [7:0] byte to transmit, sampled on the accepting edge
//   valid  in   in holds a byte to send
//   ready  out  block accepts a byte this cycle (registered)
//   out    out  serial line: idle 0, start 1, stop 0 (registered)
//   busy   out  a frame is on the line, start through stop bit (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       busy
);

  localparam int            CW     = $clog2(DIV);
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] divCnt_q, divCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  logic          accept;
  logic          bitEnd;
  logic          pendingValid;
  logic [7:0]    pendingByte;
  logic          frameLoad;

  assign accept = valid && ready_q;
  assign bitEnd = (divCnt_q == CntMax);

  // A new frame is loaded either straight out of idle or on the edge that
  // ends a stop bit, provided some byte is waiting to go.
  assign frameLoad = pendingValid &&
                     ((state_q == IDLE) || ((state_q == STOP) && bitEnd));

`ifdef UART_TX_HOLD_EN
  logic       holdValid_q, holdValid_d;
  logic [7:0] holdByte_q, holdByte_d;

  // The slot always has priority over a fresh byte so ordering is kept.
  assign pendingValid = holdValid_q || accept;
  assign pendingByte  = holdValid_q ? holdByte_q : in;

  // Slot update. When the slot drains into the shifter on the same edge a
  // byte is accepted, the new byte takes the slot's place. A byte accepted
  // while no frame load happens parks in the slot.
  always_comb begin
    holdValid_d = holdValid_q;
    holdByte_d  = holdByte_q;
    if (frameLoad && holdValid_q) begin
      holdValid_d = accept;
      holdByte_d  = in;
    end else if (accept && !frameLoad) begin
      holdValid_d = 1'b1;
      holdByte_d  = in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdValid_q <= 1'b0;
      holdByte_q  <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdByte_q  <= holdByte_d;
    end
  end
`else
  assign pendingValid = accept;
  assign pendingByte  = in;
`endif

  // State and datapath registers. Reset abandons any partial frame and
  // forces the line low at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      divCnt_q <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic. The divide counter runs 0..DIV-1 in every non-idle
  // state and wraps on the edge that ends a bit, so each bit lasts DIV cycles.
  always_comb begin
    state_d  = state_q;
    divCnt_d = bitEnd ? '0 : divCnt_q + CW'(1);
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: begin
        divCnt_d = '0;
        bitIdx_d = '0;
        if (frameLoad) begin
          state_d = START;
          shift_d = pendingByte;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (frameLoad) begin
            state_d = START;
            shift_d = pendingByte;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. Outputs are decoded from the next state so that, once
  // registered, they line up with the state they describe; the shifter's
  // next value already holds the bit that goes on the line.
  always_comb begin
    out_d  = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   out_d = 1'b1;
      DATA:    out_d = shift_d[0];
      default: out_d = 1'b0;
    endcase
`ifdef UART_TX_HOLD_EN
    ready_d = !holdValid_d;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  assign out   = out_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule
